// File: rtl/seq_shift_add_mul_if.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mul_if
//
// Purpose : Handshake and operand/result bundle for the seq_shift_add_mul
//           sequential multiplier.
//
// Signals :
//   start    requester -> engine  1        operation request (used in IDLE only)
//   a        requester -> engine  WIDTH    multiplicand
//   b        requester -> engine  WIDTH    multiplier
//   busy     engine -> requester  1        high while an operation is in flight
//   done     engine -> requester  1        one-cycle pulse when product updates
//   product  engine -> requester  2*WIDTH  result, held until the next done
//
// Modports:
//   master  the requester (controller, bus wrapper or testbench)
//   slave   the multiplier engine
// -----------------------------------------------------------------------------
interface seq_shift_add_mul_if #(
   parameter int WIDTH = 16
);

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output product
   );

endinterface : seq_shift_add_mul_if

// File: rtl/seq_shift_add_mul.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mul
//
// Purpose : Radix-2 shift-and-add sequential multiplier. One partial product
//           is accumulated per clock, so every operation takes exactly WIDTH
//           iterations regardless of operand values. The full 2*WIDTH-bit
//           product is delivered, so the result can never overflow.
//
// Ports   :
//   clk    input   rising-edge clock
//   rst_n  input   asynchronous active-low reset; clears every register and
//                  aborts an operation in flight without a done pulse
//   bus    slave   seq_shift_add_mul_if (start/a/b in, busy/done/product out)
//
// Timing  : start accepted at edge E0 (IDLE only), CALC on edges E1..E_WIDTH,
//           DONE ends at edge E_WIDTH+1 where product is written; done is high
//           for the single cycle after that edge. busy is high in CALC and DONE.
//           Throughput is one multiply per WIDTH+2 cycles.
//
// Options : `define MUL_SIGNED_EN selects two's-complement operands. The
//           multiplicand is then sign-extended at load and the last iteration
//           subtracts instead of adding, because the MSB of b carries weight
//           -2^(WIDTH-1). Without the macro no subtract path is built.
//
// Parameters:
//   WIDTH  operand width, legal range 2..64
//   CNT_W  iteration counter width, derived from WIDTH (local, not overridable)
// -----------------------------------------------------------------------------
module seq_shift_add_mul #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seq_shift_add_mul_if.slave     bus
);

   // ---------------------------------------------------------------------------
   // Local parameters
   // ---------------------------------------------------------------------------
   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Counter value on the last CALC iteration.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Widen an operand to the accumulator width: sign extension in signed mode,
   // zero extension otherwise.
   function automatic logic [PW-1:0] ext_operand(input logic [WIDTH-1:0] op);
`ifdef MUL_SIGNED_EN
      ext_operand = {{WIDTH{op[WIDTH-1]}}, op};
`else
      ext_operand = {{WIDTH{1'b0}}, op};
`endif
   endfunction

   // ---------------------------------------------------------------------------
   // Registers and next-state signals
   // ---------------------------------------------------------------------------
   state_t              state_r;
   state_t              next_state_s;

   logic [PW-1:0]       mcand_r;
   logic [PW-1:0]       mcand_nxt_s;
   logic [WIDTH-1:0]    mplr_r;
   logic [WIDTH-1:0]    mplr_nxt_s;
   logic [PW-1:0]       acc_r;
   logic [PW-1:0]       acc_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;

   logic [PW-1:0]       product_r;
   logic [PW-1:0]       product_nxt_s;
   logic                done_r;
   logic                done_nxt_s;
   logic                busy_r;
   logic                busy_nxt_s;

   logic                last_iter_s;
   logic [PW-1:0]       acc_step_s;

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------

   // Flags the iteration that consumes the multiplier MSB.
   always_comb begin
      last_iter_s = (cnt_r == CNT_LAST);
   end

   // Accumulator update used when the current multiplier bit is set. In signed
   // mode the MSB partial product is negative, hence the subtract on the last
   // iteration; the arithmetic wraps modulo 2^(2*WIDTH) in both modes.
   always_comb begin
`ifdef MUL_SIGNED_EN
      if (last_iter_s) begin
         acc_step_s = acc_r - mcand_r;
      end else begin
         acc_step_s = acc_r + mcand_r;
      end
`else
      acc_step_s = acc_r + mcand_r;
`endif
   end

   // ---------------------------------------------------------------------------
   // Control FSM: next state, datapath loads and registered-output next values
   // ---------------------------------------------------------------------------

   // Next-state and next-register-value logic; every target holds by default.
   always_comb begin
      next_state_s  = state_r;
      mcand_nxt_s   = mcand_r;
      mplr_nxt_s    = mplr_r;
      acc_nxt_s     = acc_r;
      cnt_nxt_s     = cnt_r;
      product_nxt_s = product_r;
      done_nxt_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // Operands are captured only here; a or b moving later is ignored.
            if (bus.start) begin
               mcand_nxt_s  = ext_operand(bus.a);
               mplr_nxt_s   = bus.b;
               acc_nxt_s    = {PW{1'b0}};
               cnt_nxt_s    = CNT_ZERO;
               next_state_s = ST_CALC;
            end else begin
               next_state_s = ST_IDLE;
            end
         end

         ST_CALC: begin
            // start is deliberately not looked at here: requests while busy
            // are dropped, not queued.
            if (mplr_r[0]) begin
               acc_nxt_s = acc_step_s;
            end else begin
               acc_nxt_s = acc_r;
            end
            mcand_nxt_s = {mcand_r[PW-2:0], 1'b0};
            mplr_nxt_s  = {1'b0, mplr_r[WIDTH-1:1]};
            cnt_nxt_s   = cnt_r + CNT_ONE;

            if (last_iter_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_CALC;
            end
         end

         ST_DONE: begin
            // product only ever changes on this edge, so it is stable through
            // the whole of the following operation.
            product_nxt_s = acc_r;
            done_nxt_s    = 1'b1;
            next_state_s  = ST_IDLE;
         end

         default: begin
            next_state_s = ST_IDLE;
         end
      endcase

      busy_nxt_s = (next_state_s != ST_IDLE);
   end

   // ---------------------------------------------------------------------------
   // Sequential elements
   // ---------------------------------------------------------------------------

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Iteration datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r <= {PW{1'b0}};
         mplr_r  <= {WIDTH{1'b0}};
         acc_r   <= {PW{1'b0}};
         cnt_r   <= CNT_ZERO;
      end else begin
         mcand_r <= mcand_nxt_s;
         mplr_r  <= mplr_nxt_s;
         acc_r   <= acc_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_r <= {PW{1'b0}};
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         product_r <= product_nxt_s;
         done_r    <= done_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

   // ---------------------------------------------------------------------------
   // Output drive
   // ---------------------------------------------------------------------------
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;

endmodule : seq_shift_add_mul

// File: tb/tb_seq_shift_add_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mul
//
// Self-checking bench for seq_shift_add_mul at WIDTH=16. Expected products come
// from plain integer multiplication (signed when MUL_SIGNED_EN is defined).
// -----------------------------------------------------------------------------
module tb_seq_shift_add_mul;

   localparam int W   = 16;
   localparam int LAT = W + 1;   // negedges from the accepting edge to done

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   seq_shift_add_mul_if #(.WIDTH(W)) bus ();

   seq_shift_add_mul #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference multiply straight from the arithmetic definition.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_SIGNED_EN
      logic signed [2*W-1:0] sx;
      logic signed [2*W-1:0] sy;
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      ref_mul = sx * sy;
`else
      ref_mul = {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
   endfunction

   // Start one operation and observe it up to (and one cycle past) done.
   // lat is the done sample index (0 = first negedge after the accepting edge).
   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input bit scramble,
                         output int lat, output int busy_cycles, output bit stable,
                         output logic [2*W-1:0] prod, output bit busy_at_done,
                         output bit done_after);
      logic [2*W-1:0] prev;
      prev = bus.product;
      @(negedge clk);
      bus.a     = op_a;
      bus.b     = op_b;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = -1;
      busy_cycles = 0;
      stable = 1'b1;
      busy_at_done = 1'b1;
      prod = '0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.done) begin
            lat = k;
            prod = bus.product;
            busy_at_done = bus.busy;
         end else begin
            if (bus.busy) busy_cycles++;
            if (bus.product !== prev) stable = 1'b0;
            if (scramble) begin
               bus.a = W'($urandom);
               bus.b = W'($urandom);
            end
         end
      end
      @(negedge clk);
      done_after = bus.done;
   endtask

   task automatic test_reset;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: busy=%b done=%b product=%h, required 0/0/0",
                  bus.busy, bus.done, bus.product);
      end
   endtask

   task automatic test_directed;
      logic [W-1:0]   va [4];
      logic [W-1:0]   vb [4];
      logic [2*W-1:0] vp [4];
      int n;
      int lat, bc;
      bit st, bad, da;
      logic [2*W-1:0] p;
`ifdef MUL_SIGNED_EN
      va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vp[0] = 32'h0000_0001;
      va[1] = 16'h0007; vb[1] = 16'hFFFD; vp[1] = 32'hFFFF_FFEB;
      va[2] = 16'h8000; vb[2] = 16'h8000; vp[2] = 32'h4000_0000;
      va[3] = 16'h8000; vb[3] = 16'h7FFF; vp[3] = 32'hC000_8000;
      n = 4;
`else
      va[0] = 16'h0003; vb[0] = 16'h0005; vp[0] = 32'h0000_000F;
      va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vp[1] = 32'hFFFE_0001;
      va[2] = 16'h0000; vb[2] = 16'h1234; vp[2] = 32'h0000_0000;
      va[3] = 16'h1234; vb[3] = 16'h0000; vp[3] = 32'h0000_0000;
      n = 4;
`endif
      for (int i = 0; i < n; i++) begin
         run_op(va[i], vb[i], 1'b0, lat, bc, st, p, bad, da);
         tests_run++;
         if (p !== vp[i]) begin
            tests_failed++;
            $display("FAIL directed_product[%0d]: got %h, required %h", i, p, vp[i]);
         end
         tests_run++;
         if (lat != LAT || bc != LAT) begin
            tests_failed++;
            $display("FAIL directed_latency[%0d]: done at %0d busy %0d cycles, required %0d/%0d",
                     i, lat, bc, LAT, LAT);
         end
         tests_run++;
         if (bad !== 1'b0 || da !== 1'b0) begin
            tests_failed++;
            $display("FAIL directed_done_pulse[%0d]: busy_at_done=%b done_next=%b, required 0/0",
                     i, bad, da);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] x, y;
      int lat, bc;
      bit st, bad, da;
      logic [2*W-1:0] p;
      for (int i = 0; i < 16; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         if (i == 0) x = '0;
         if (i == 1) y = {W{1'b1}};
         if (i == 2) x = {1'b1, {(W-1){1'b0}}};
         run_op(x, y, 1'b1, lat, bc, st, p, bad, da);
         tests_run++;
         if (p !== ref_mul(x, y) || lat != LAT || !st || da !== 1'b0) begin
            tests_failed++;
            $display("FAIL random[%0d] a=%h b=%h: product %h lat %0d stable %0d done_next %b, required %h lat %0d stable 1 done_next 0",
                     i, x, y, p, lat, st, da, ref_mul(x, y), LAT);
         end
      end
   endtask

   task automatic test_busy_guard;
      int dones;
      logic [2*W-1:0] p;
      int lat, bc;
      bit st, bad, da;
      @(negedge clk);
      bus.a = 16'd2; bus.b = 16'd4; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      p = '0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.done) begin
            dones++;
            p = bus.product;
         end
         bus.start = 1'b0;
         if (k == 3 || k == 10) begin
            bus.a = 16'd9; bus.b = 16'd9; bus.start = 1'b1;
         end
      end
      bus.start = 1'b0;
      tests_run++;
      if (dones != 1) begin
         tests_failed++;
         $display("FAIL busy_guard_done_count: got %0d, required 1", dones);
      end
      tests_run++;
      if (p !== ref_mul(16'd2, 16'd4) || p !== 32'h0000_0008) begin
         tests_failed++;
         $display("FAIL busy_guard_product: got %h, required 00000008", p);
      end
      run_op(16'd9, 16'd9, 1'b0, lat, bc, st, p, bad, da);
      tests_run++;
      if (p !== 32'd81 || lat != LAT) begin
         tests_failed++;
         $display("FAIL busy_guard_next_op: product %h lat %0d, required 00000051 lat %0d",
                  p, lat, LAT);
      end
   endtask

   task automatic test_reset_mid;
      int dones;
      int lat, bc;
      bit st, bad, da;
      logic [2*W-1:0] p;
      @(negedge clk);
      bus.a = 16'h1357; bus.b = 16'h2468; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_immediate: busy=%b done=%b product=%h, required 0/0/0",
                  bus.busy, bus.done, bus.product);
      end
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      tests_run++;
      if (dones != 0) begin
         tests_failed++;
         $display("FAIL reset_mid_no_done: %0d done/busy samples, required 0", dones);
      end
      run_op(16'd7, 16'd6, 1'b0, lat, bc, st, p, bad, da);
      tests_run++;
      if (p !== 32'd42 || lat != LAT) begin
         tests_failed++;
         $display("FAIL reset_mid_recover: product %h lat %0d, required 0000002a lat %0d",
                  p, lat, LAT);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] x1, y1, x2, y2;
      int t1, t2;
      bit held;
      logic [2*W-1:0] p1, p2;
      x1 = W'($urandom); y1 = W'($urandom);
      x2 = W'($urandom); y2 = W'($urandom);
      @(negedge clk);
      bus.a = x1; bus.b = y1; bus.start = 1'b1;
      t1 = -1; t2 = -1; held = 1'b1;
      p1 = '0; p2 = '0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.a = x2; bus.b = y2;
         end
         if (k == 2 * LAT - 16) bus.start = 1'b0;
         if (bus.done) begin
            if (t1 < 0) begin
               t1 = k; p1 = bus.product;
            end else if (t2 < 0) begin
               t2 = k; p2 = bus.product;
            end
         end else if (t1 >= 0 && t2 < 0 && bus.product !== p1) begin
            held = 1'b0;
         end
      end
      bus.start = 1'b0;
      tests_run++;
      if (t1 != LAT || t2 != 2 * LAT + 1) begin
         tests_failed++;
         $display("FAIL back_to_back_timing: dones at %0d and %0d, required %0d and %0d",
                  t1, t2, LAT, 2 * LAT + 1);
      end
      tests_run++;
      if (p1 !== ref_mul(x1, y1) || p2 !== ref_mul(x2, y2) || !held) begin
         tests_failed++;
         $display("FAIL back_to_back_products: %h %h held %0d, required %h %h held 1",
                  p1, p2, held, ref_mul(x1, y1), ref_mul(x2, y2));
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      #1;
      test_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_directed();
      test_random();
      test_busy_guard();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_seq_shift_add_mul
